// File: rtl/bus_slave_responder.sv
// Slave endpoint of the serial system bus: decodes request frames, stores write
// bursts into a local word memory and serialises read bursts back to the bus.
module bus_slave_responder #(
    parameter int ADDR_LEN     = 12,
    parameter int DATA_LEN     = 8,
    parameter int BURST_LEN    = 12,
    parameter int MEM_ADDR_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_valid,
    input  logic rx_bit,
    input  logic tx_ready,
    output logic slave_ready,
    output logic tx_valid,
    output logic tx_bit,
    output logic write_done,
    output logic read_done,
    output logic frame_err
);

    localparam int HDR_LEN = ADDR_LEN + BURST_LEN;
    localparam int CNT_MAX = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HW      = MEM_ADDR_LEN + BURST_LEN;
    localparam int DEPTH   = 2 ** MEM_ADDR_LEN;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_DONE_W,
        S_RFETCH,
        S_RSHIFT,
        S_DONE_R
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_q, cmd_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [HW-2:0]           hdr_q, hdr_d;
    logic [DATA_LEN-2:0]     word_q, word_d;
    logic [DATA_LEN-1:0]     shreg_q, shreg_d;
    logic [MEM_ADDR_LEN-1:0] idx_q, idx_d;
    logic [BURST_LEN-1:0]    wcnt_q, wcnt_d;
    logic [BURST_LEN-1:0]    nwords_q, nwords_d;

    logic [DATA_LEN-1:0]     mem [DEPTH];
    logic                    mem_we;
    logic [HW-1:0]           hdr_full;
    logic [DATA_LEN-1:0]     word_full;
    logic [BURST_LEN-1:0]    wcnt_inc;
    logic                    last_word;

    // Only the low address bits and the burst field are kept; older header bits fall off the top.
    assign hdr_full  = {hdr_q, rx_bit};
    assign word_full = {word_q, rx_bit};
    assign wcnt_inc  = wcnt_q + BURST_LEN'(1);
    assign last_word = (wcnt_inc == nwords_q);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bit_cnt_d   = bit_cnt_q;
        hdr_d       = hdr_q;
        word_d      = word_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        nwords_d    = nwords_q;
        mem_we      = 1'b0;
        slave_ready = 1'b0;
        tx_valid    = 1'b0;
        tx_bit      = 1'b0;
        write_done  = 1'b0;
        read_done   = 1'b0;
        frame_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                slave_ready = 1'b1;
                if (rx_valid) begin
                    cmd_d     = rx_bit;
                    bit_cnt_d = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (!rx_valid) begin
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    hdr_d     = hdr_full[HW-2:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == HDR_LAST) begin
                        idx_d     = hdr_full[HW-1 -: MEM_ADDR_LEN];
                        nwords_d  = (hdr_full[BURST_LEN-1:0] == '0) ? BURST_LEN'(1)
                                                                    : hdr_full[BURST_LEN-1:0];
                        wcnt_d    = '0;
                        bit_cnt_d = '0;
                        state_d   = cmd_q ? S_RFETCH : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (!rx_valid) begin
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    word_d    = word_full[DATA_LEN-2:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == WORD_LAST) begin
                        mem_we    = 1'b1;
                        idx_d     = idx_q + MEM_ADDR_LEN'(1);
                        wcnt_d    = wcnt_inc;
                        bit_cnt_d = '0;
                        if (last_word) begin
                            state_d = S_DONE_W;
                        end
                    end
                end
            end
            S_DONE_W: begin
                write_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_RFETCH: begin
                shreg_d   = mem[idx_q];
                bit_cnt_d = '0;
                state_d   = S_RSHIFT;
            end
            S_RSHIFT: begin
                tx_valid = 1'b1;
                tx_bit   = shreg_q[DATA_LEN-1];
                if (tx_ready) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == WORD_LAST) begin
                        idx_d     = idx_q + MEM_ADDR_LEN'(1);
                        wcnt_d    = wcnt_inc;
                        bit_cnt_d = '0;
                        state_d   = last_word ? S_DONE_R : S_RFETCH;
                    end
                end
            end
            S_DONE_R: begin
                read_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= 1'b0;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            word_q    <= '0;
            shreg_q   <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            nwords_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            bit_cnt_q <= bit_cnt_d;
            hdr_q     <= hdr_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            nwords_q  <= nwords_d;
        end
    end

    // Memory contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx_q] <= word_full;
        end
    end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Scoreboard bench for bus_slave_responder: expected read bits and done/error
// events are queued as frames are driven and consumed by a negedge monitor.
module tb_bus_slave_responder;

    logic clk;
    logic reset;
    logic rx_valid;
    logic rx_bit;
    logic tx_ready;
    logic slave_ready;
    logic tx_valid;
    logic tx_bit;
    logic write_done;
    logic read_done;
    logic frame_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] wq [$];
    bit         exp_bits [$];
    logic [2:0] exp_evt [$];
    logic [2:0] evt_code;

    localparam logic [2:0] EVT_WR  = 3'b001;
    localparam logic [2:0] EVT_RD  = 3'b010;
    localparam logic [2:0] EVT_ERR = 3'b100;

    bus_slave_responder dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_bit      (rx_bit),
        .tx_ready    (tx_ready),
        .slave_ready (slave_ready),
        .tx_valid    (tx_valid),
        .tx_bit      (tx_bit),
        .write_done  (write_done),
        .read_done   (read_done),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request frame, stopping after `limit` bits (the whole frame when negative).
    task automatic applyStimulus(input logic cmd, input logic [11:0] addr, input logic [11:0] burst,
                                 input int n_words, input int limit);
        bit bq [$];
        int waited;
        int n_send;
        waited = 0;
        while (!slave_ready && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("ready_wait", {31'b0, slave_ready}, 32'd1);
        bq.push_back(cmd);
        for (int i = 11; i >= 0; i--) bq.push_back(addr[i]);
        for (int i = 11; i >= 0; i--) bq.push_back(burst[i]);
        if (!cmd) begin
            for (int w = 0; w < n_words; w++)
                for (int i = 7; i >= 0; i--) bq.push_back(wq[w][i]);
        end
        n_send = (limit < 0 || limit > bq.size()) ? bq.size() : limit;
        for (int b = 0; b < n_send; b++) begin
            rx_valid = 1'b1;
            rx_bit   = bq[b];
            step();
        end
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
    endtask

    task automatic writeFrame(input logic [11:0] addr, input logic [11:0] burst, input int limit);
        int n;
        int frame_bits;
        int sent;
        n          = (burst == 12'd0) ? 1 : int'(burst);
        frame_bits = 25 + 8 * n;
        sent       = (limit < 0 || limit > frame_bits) ? frame_bits : limit;
        for (int w = 0; w < n; w++)
            if (25 + 8 * (w + 1) <= sent) ref_mem[8'(addr + 12'(w))] = wq[w];
        exp_evt.push_back((sent == frame_bits) ? EVT_WR : EVT_ERR);
        applyStimulus(1'b0, addr, burst, n, sent);
        step();
        checkOutput("wr_ready_after", {31'b0, slave_ready}, 32'd1);
        checkOutput("wr_evt_left", exp_evt.size(), 32'd0);
    endtask

    // mode 0: tx_ready always high; mode 1: tx_ready pattern 1,0,0 repeating.
    task automatic readFrame(input logic [11:0] addr, input logic [11:0] burst, input int mode);
        int n;
        int first_valid;
        int bubbles;
        bit done;
        logic [7:0] word;
        n = (burst == 12'd0) ? 1 : int'(burst);
        for (int w = 0; w < n; w++) begin
            word = ref_mem[8'(addr + 12'(w))];
            for (int i = 7; i >= 0; i--) exp_bits.push_back(word[i]);
        end
        exp_evt.push_back(EVT_RD);
        applyStimulus(1'b1, addr, burst, 0, -1);
        first_valid = -1;
        bubbles     = 0;
        done        = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (read_done) begin
                done = 1'b1;
            end else begin
                if (tx_valid && first_valid < 0) first_valid = cyc;
                if (!tx_valid && first_valid >= 0) bubbles++;
                tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
                step();
            end
        end
        tx_ready = 1'b0;
        checkOutput("rd_done_seen", {31'b0, done}, 32'd1);
        checkOutput("rd_latency", first_valid, 32'd1);
        checkOutput("rd_bubbles", bubbles, n - 1);
        checkOutput("rd_bits_left", exp_bits.size(), 32'd0);
        step();
        checkOutput("rd_ready_after", {31'b0, slave_ready}, 32'd1);
        checkOutput("rd_evt_left", exp_evt.size(), 32'd0);
    endtask

    // Monitor: every pulse must match the next queued event; every valid bit the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            evt_code = {frame_err, read_done, write_done};
            if (evt_code != 3'b000) begin
                if (exp_evt.size() == 0) checkOutput("evt_unexpected", {29'b0, evt_code}, 32'd0);
                else checkOutput("evt", {29'b0, evt_code}, {29'b0, exp_evt.pop_front()});
            end
            if (tx_valid) begin
                if (exp_bits.size() == 0) begin
                    checkOutput("tx_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("tx_bit", {31'b0, tx_bit}, {31'b0, exp_bits[0]});
                    if (tx_ready) void'(exp_bits.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        tx_ready = 1'b0;
        repeat (3) step();
        checkOutput("rst_slave_ready", {31'b0, slave_ready}, 32'd1);
        checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("rst_tx_bit", {31'b0, tx_bit}, 32'd0);
        checkOutput("rst_pulses", {29'b0, write_done, read_done, frame_err}, 32'd0);
        reset = 1'b0;
        step();

        wq = '{8'hA5};
        writeFrame(12'h003, 12'd1, -1);
        readFrame(12'h003, 12'd1, 0);

        wq = '{8'h11, 8'h22, 8'h33};
        writeFrame(12'h0FF, 12'd3, -1);
        readFrame(12'h0FF, 12'd3, 0);

        readFrame(12'h003, 12'd1, 1);
        readFrame(12'hA03, 12'd1, 0);

        wq = '{8'h99};
        writeFrame(12'h011, 12'd1, -1);
        wq = '{8'h5A};
        writeFrame(12'h010, 12'd0, -1);
        readFrame(12'h010, 12'd2, 0);

        wq = '{8'h77};
        writeFrame(12'h021, 12'd1, -1);
        wq = '{8'hC3, 8'h3C};
        writeFrame(12'h020, 12'd2, 25 + 12);
        readFrame(12'h020, 12'd2, 0);

        // Reset in the middle of a read: no read_done, and the memory keeps its data.
        exp_bits.delete();
        for (int i = 7; i >= 0; i--) exp_bits.push_back(ref_mem[3][i]);
        applyStimulus(1'b1, 12'h003, 12'd1, 0, -1);
        tx_ready = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        tx_ready = 1'b0;
        checkOutput("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("midrst_slave_ready", {31'b0, slave_ready}, 32'd1);
        exp_bits.delete();
        repeat (3) step();
        readFrame(12'h003, 12'd1, 0);

        repeat (3) step();
        checkOutput("final_bits_left", exp_bits.size(), 32'd0);
        checkOutput("final_evt_left", exp_evt.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
